// File: rtl/sseg_pkg.sv
// ============================================================================
// sseg_pkg : shared constants for the seven-segment scan driver
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package sseg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int         DP_BIT    = 7;

  // Segment patterns {g,f,e,d,c,b,a}, entry 15 (F) first down to entry 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sseg_hex_decode.sv
// ============================================================================
// sseg_hex_decode : combinational hex nibble to 7-segment pattern {g..a}
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

`default_nettype wire

// File: rtl/sseg_scan_driver.sv
// ============================================================================
// sseg_scan_driver : time-multiplexed N-digit seven-segment driver with a
//                    double-buffered value; frame-aligned display updates.
// Option macro     : SSEG_LEADING_ZERO_BLANK_EN (dark leading-zero digits)
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  output logic [NUM_DIGITS-1:0]     Anode,
  output logic [7:0]                Cathode,
  output logic                      frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0]         C_CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         C_IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] C_AN_OFF   = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_val, r_act_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;
  logic [NUM_DIGITS-1:0]   r_pend_bl, r_act_bl;
  logic                    r_pend_valid;

  logic                    w_tick, w_last, w_wrap;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg;
  logic                    w_dp, w_bl, w_lz;
  logic [NUM_DIGITS-1:0]   w_onehot, w_anode_on;
  logic [7:0]              w_cathode;

  assign w_tick = en && (r_cnt == C_CNT_MAX);
  assign w_last = (r_idx == C_IDX_LAST);
  assign w_wrap = w_tick && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (en) begin
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Active buffer only changes on the wrap tick so a frame never shows mixed values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_bl    <= '0;
      r_pend_valid <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_act_bl     <= '0;
    end else begin
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_mask;
        r_pend_bl  <= blank_mask;
      end
      if (w_wrap) begin
        r_pend_valid <= 1'b0;
        if (load) begin
          r_act_val <= value;
          r_act_dp  <= dp_mask;
          r_act_bl  <= blank_mask;
        end else if (r_pend_valid) begin
          r_act_val <= r_pend_val;
          r_act_dp  <= r_pend_dp;
          r_act_bl  <= r_pend_bl;
        end
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign w_nib = r_act_val[4*r_idx +: 4];
  assign w_dp  = r_act_dp[r_idx];
  assign w_bl  = r_act_bl[r_idx];

  sseg_hex_decode u_dec (
    .nibble (w_nib),
    .seg    (w_seg)
  );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] w_msd;

  // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 still shows "0".
  always_comb begin
    w_msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (r_act_val[4*i +: 4] != 4'h0) w_msd = IW'(i);
    end
  end

  assign w_lz = (r_idx > w_msd);
`else
  assign w_lz = 1'b0;
`endif

  assign w_onehot   = NUM_DIGITS'(1) << r_idx;
  assign w_anode_on = (ANODE_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
  assign w_cathode  = w_bl ? SEG_BLANK
                    : w_lz ? {w_dp, 7'h00}
                    :        {w_dp, w_seg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Anode      <= C_AN_OFF;
      Cathode    <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_wrap;
      if (en) begin
        Anode   <= w_anode_on;
        Cathode <= w_cathode;
      end else begin
        Anode   <= C_AN_OFF;
        Cathode <= SEG_BLANK;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
// ============================================================================
// tb_sseg_scan_driver : scoreboard bench for sseg_scan_driver (4 digits, div 4)
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module tb_sseg_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_mask = '0;
  logic [3:0]    blank_mask = '0;
  logic [3:0]    Anode;
  logic [7:0]    Cathode;
  logic          frame_done;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [12:0]   sb_q[$];

  // reference state
  int            m_cnt, m_idx;
  logic [15:0]   m_aval, m_pval;
  logic [3:0]    m_adp, m_abl, m_pdp, m_pbl;
  logic          m_pv;

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .NUM_DIGITS       (N),
    .REFRESH_DIV      (DIV),
    .ANODE_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .Anode      (Anode),
    .Cathode    (Cathode),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0;
    m_aval = '0; m_adp = '0; m_abl = '0;
    m_pval = '0; m_pdp = '0; m_pbl = '0; m_pv = 1'b0;
  endtask

  // One clock: predict outputs for the coming edge, push, advance model, then compare.
  task automatic step();
    logic [3:0]  an;
    logic [7:0]  ca;
    logic        tick, wrap, lz;
    int          msd;
    logic [12:0] exp;
    tick = en && (m_cnt == DIV - 1);
    wrap = tick && (m_idx == N - 1);
    lz   = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    msd = 0;
    for (int i = 1; i < N; i++) if (m_aval[4*i +: 4] != 4'h0) msd = i;
    lz = (m_idx > msd);
`else
    msd = 0;
`endif
    if (!en) begin
      an = 4'hF;
      ca = 8'h00;
    end else begin
      an = ~(4'b0001 << m_idx);
      if (m_abl[m_idx])  ca = 8'h00;
      else if (lz)       ca = {m_adp[m_idx], 7'h00};
      else               ca = {m_adp[m_idx], seg7(m_aval[4*m_idx +: 4])};
    end
    sb_q.push_back({an, ca, wrap});

    if (en) begin
      if (tick) begin
        m_cnt = 0;
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt++;
      end
    end
    if (wrap) begin
      if (load) begin
        m_aval = value; m_adp = dp_mask; m_abl = blank_mask;
      end else if (m_pv) begin
        m_aval = m_pval; m_adp = m_pdp; m_abl = m_pbl;
      end
      m_pv = 1'b0;
    end else if (load) begin
      m_pv = 1'b1;
    end
    if (load) begin
      m_pval = value; m_pdp = dp_mask; m_pbl = blank_mask;
    end

    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check("scan", {19'd0, Anode, Cathode, frame_done}, {19'd0, exp});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value = v; dp_mask = dp; blank_mask = bl; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (frame_done === 1'b1) found = 1'b1;
    end
    if (!found) check(tag, {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_anode(input string tag, input logic [3:0] pat);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (Anode === pat) found = 1'b1;
    end
    if (!found) check(tag, {28'd0, Anode}, {28'd0, pat});
  endtask

  initial begin
    int fd_cnt;
    model_reset();

    // asynchronous reset, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_anode", {28'd0, Anode}, 32'h0000000F);
    check("rst_cath",  {24'd0, Cathode}, 32'h00000000);
    check("rst_fd",    {31'd0, frame_done}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // first frame shows reset contents, 1239 appears after the first wrap
    en = 1'b1;
    do_load(16'h1239, 4'h0, 4'h0);
    wait_fd("first_wrap");
    step();
    check("d0_anode", {28'd0, Anode}, 32'h0000000E);
    check("d0_cath",  {24'd0, Cathode}, 32'h0000006F);

    // free-running: exactly one frame_done per 16 clocks
    fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (frame_done === 1'b1) fd_cnt++;
    end
    check("fd_count", fd_cnt, 32'd2);

    // mid-frame load does not disturb the current frame
    wait_fd("pre_mid");
    steps(5);
    do_load(16'hABCD, 4'h0, 4'h0);
    wait_anode("mid_an2", 4'b1011);
    check("mid_keep", {24'd0, Cathode}, 32'h0000005B);
    wait_fd("mid_wrap");
    step();
    check("new_frame", {24'd0, Cathode}, 32'h0000005E);

    // decimal point on digit 0, blank on digit 2
    do_load(16'h1239, 4'b0001, 4'b0100);
    wait_fd("mask_wrap");
    step();
    check("dp0", {24'd0, Cathode}, 32'h000000EF);
    wait_anode("blank_an2", 4'b1011);
    check("blank2", {24'd0, Cathode}, 32'h00000000);

    // disabled: dark display, scan frozen, loads still accepted
    en = 1'b0;
    steps(2);
    check("dark_anode", {28'd0, Anode}, 32'h0000000F);
    check("dark_cath",  {24'd0, Cathode}, 32'h00000000);
    do_load(16'h5A5A, 4'b1010, 4'h0);
    steps(3);
    en = 1'b1;
    steps(40);

    // asynchronous reset in the middle of a frame
    steps(3);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_anode", {28'd0, Anode}, 32'h0000000F);
    check("mrst_cath",  {24'd0, Cathode}, 32'h00000000);
    check("mrst_fd",    {31'd0, frame_done}, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    steps(20);

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    do_load(16'h0042, 4'h0, 4'h0);
    wait_fd("lz_wrap");
    steps(16);
    do_load(16'h0000, 4'h0, 4'h0);
    wait_fd("lz0_wrap");
    step();
    check("lz_zero", {24'd0, Cathode}, 32'h0000003F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
